nabp_host_angle_sequencer: RTL and testbench

Host-side angle source and sinogram address generator for the filtered-RAM swap controller. It answers the swap controller's next-angle requests by offering projection angles from a configured arithmetic sequence. Each request gets a single-cycle acknowledge, a filter-clear pulse and an advance to the next angle. It also translates the swap controller's `hs_s_val` into a linear sinogram RAM address for the angle most recently handed over.

---
 rtl/nabp_host_angle_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_nabp_host_angle_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_host_angle_sequencer.sv
// nabp_host_angle_sequencer
//
// Host-side angle source for the filtered-RAM swap controller. It offers
// projection angles from the arithmetic sequence kAngleStart, +kAngleStep, ...
// (strictly below kAngleEnd). It acknowledges each next-angle request exactly
// once, with a coincident filter-clear pulse. It also maps hs_s_val to a
// linear sinogram RAM address for the angle most recently handed over.
//
// Ports:
//   clk               - single clock
//   reset_n           - asynchronous active-low reset
//   start             - one-cycle scan start, honoured only when idle
//   hs_next_angle     - level request from the swap controller
//   hs_s_val          - projection-line index from the swap controller
//   hs_angle          - angle currently on offer
//   hs_has_next_angle - hs_angle is valid and unconsumed
//   hs_next_angle_ack - one-cycle request acknowledge
//   filter_clear      - one-cycle pulse, coincident with the ack
//   fill_angle        - angle most recently handed over
//   sg_addr           - registered sinogram address fill_idx*line_size + s_val
//   busy              - sequencer not idle
//   done              - one-cycle end-of-scan pulse
//
// Build option: define NABP_SEQ_REPEAT_EN to restart the scan after every
// drain request instead of returning to idle.

module nabp_host_angle_sequencer #(
    parameter int kAngleLength        = 9,
    parameter int kSLength            = 8,
    parameter int kAddrLength         = 16,
    parameter int kProjectionLineSize = 256,
    parameter int kAngleStart         = 0,
    parameter int kAngleEnd           = 180,
    parameter int kAngleStep          = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    hs_next_angle,
    input  logic [kSLength-1:0]     hs_s_val,
    output logic [kAngleLength-1:0] hs_angle,
    output logic                    hs_has_next_angle,
    output logic                    hs_next_angle_ack,
    output logic                    filter_clear,
    output logic [kAngleLength-1:0] fill_angle,
    output logic [kAddrLength-1:0]  sg_addr,
    output logic                    busy,
    output logic                    done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_OFFER    = 3'd1;
    localparam logic [2:0] S_ADVANCE  = 3'd2;
    localparam logic [2:0] S_WAIT_LOW = 3'd3;
    localparam logic [2:0] S_LAST     = 3'd4;

    localparam logic [kAngleLength-1:0] ANGLE_START = kAngleLength'(kAngleStart);
    localparam logic [kAngleLength:0]   ANGLE_STEP  = (kAngleLength + 1)'(kAngleStep);
    localparam logic [kAngleLength:0]   ANGLE_END   = (kAngleLength + 1)'(kAngleEnd);
    localparam logic [kAddrLength-1:0]  LINE_SIZE   = kAddrLength'(kProjectionLineSize);

    logic [2:0]              state_q,      state_d;
    logic [kAngleLength-1:0] angle_q,      angle_d;
    logic                    has_next_q,   has_next_d;
    logic                    ack_q,        ack_d;
    logic                    fclr_q,       fclr_d;
    logic [kAngleLength-1:0] fill_angle_q, fill_angle_d;
    logic [kAngleLength-1:0] fill_idx_q,   fill_idx_d;
    logic [kAngleLength-1:0] offer_idx_q,  offer_idx_d;
    logic [kAddrLength-1:0]  sg_addr_q,    sg_addr_d;
    logic                    done_q,       done_d;
    logic                    low_seen_q,   low_seen_d;
    logic [kAngleLength:0]   next_angle;

    always_comb begin
        state_d      = state_q;
        angle_d      = angle_q;
        has_next_d   = has_next_q;
        ack_d        = 1'b0;
        fclr_d       = 1'b0;
        done_d       = 1'b0;
        fill_angle_d = fill_angle_q;
        fill_idx_d   = fill_idx_q;
        offer_idx_d  = offer_idx_q;
        low_seen_d   = low_seen_q;
        // One extra bit so the end comparison cannot wrap.
        next_angle   = {1'b0, angle_q} + ANGLE_STEP;
        sg_addr_d    = kAddrLength'(fill_idx_q) * LINE_SIZE + kAddrLength'(hs_s_val);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    angle_d     = ANGLE_START;
                    offer_idx_d = '0;
                    has_next_d  = 1'b1;
                    state_d     = S_OFFER;
                end
            end
            S_OFFER: begin
                if (hs_next_angle) begin
                    ack_d        = 1'b1;
                    fclr_d       = 1'b1;
                    fill_angle_d = angle_q;
                    fill_idx_d   = offer_idx_q;
                    state_d      = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (next_angle >= ANGLE_END) begin
                    has_next_d = 1'b0;
                    low_seen_d = 1'b0;
                    state_d    = S_LAST;
                end else begin
                    angle_d     = next_angle[kAngleLength-1:0];
                    offer_idx_d = offer_idx_q + kAngleLength'(1);
                    state_d     = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!hs_next_angle) begin
                    state_d = S_OFFER;
                end
            end
            S_LAST: begin
                // The drain request must be a fresh rising request, not the
                // tail of the one that consumed the final angle.
                if (!low_seen_q) begin
                    if (!hs_next_angle) begin
                        low_seen_d = 1'b1;
                    end
                end else if (hs_next_angle) begin
                    done_d     = 1'b1;
                    low_seen_d = 1'b0;
`ifdef NABP_SEQ_REPEAT_EN
                    angle_d     = ANGLE_START;
                    offer_idx_d = '0;
                    has_next_d  = 1'b1;
                    state_d     = S_WAIT_LOW;
`else
                    state_d     = S_IDLE;
`endif
                end
            end
            default: begin
                state_d    = S_IDLE;
                has_next_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            angle_q      <= '0;
            has_next_q   <= 1'b0;
            ack_q        <= 1'b0;
            fclr_q       <= 1'b0;
            fill_angle_q <= '0;
            fill_idx_q   <= '0;
            offer_idx_q  <= '0;
            sg_addr_q    <= '0;
            done_q       <= 1'b0;
            low_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            has_next_q   <= has_next_d;
            ack_q        <= ack_d;
            fclr_q       <= fclr_d;
            fill_angle_q <= fill_angle_d;
            fill_idx_q   <= fill_idx_d;
            offer_idx_q  <= offer_idx_d;
            sg_addr_q    <= sg_addr_d;
            done_q       <= done_d;
            low_seen_q   <= low_seen_d;
        end
    end

    assign hs_angle          = angle_q;
    assign hs_has_next_angle = has_next_q;
    assign hs_next_angle_ack = ack_q;
    assign filter_clear      = fclr_q;
    assign fill_angle        = fill_angle_q;
    assign sg_addr           = sg_addr_q;
    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;

endmodule

// File: tb/tb_nabp_host_angle_sequencer.sv
// Directed self-checking bench for nabp_host_angle_sequencer.
// dut uses default parameters; dut2 starts at angle 170 to exercise the
// single-angle scan boundary.

module tb_nabp_host_angle_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, start, req, start2, req2;
    logic [7:0] s_val, s_val2;

    logic [8:0]  hs_angle, fill_angle, hs_angle2, fill_angle2;
    logic        has_next, ack, fclr, busy, done;
    logic        has_next2, ack2, fclr2, busy2, done2;
    logic [15:0] sg_addr, sg_addr2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    nabp_host_angle_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hs_next_angle(req),
        .hs_s_val(s_val), .hs_angle(hs_angle), .hs_has_next_angle(has_next),
        .hs_next_angle_ack(ack), .filter_clear(fclr), .fill_angle(fill_angle),
        .sg_addr(sg_addr), .busy(busy), .done(done)
    );

    nabp_host_angle_sequencer #(.kAngleStart(170)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .hs_next_angle(req2),
        .hs_s_val(s_val2), .hs_angle(hs_angle2), .hs_has_next_angle(has_next2),
        .hs_next_angle_ack(ack2), .filter_clear(fclr2), .fill_angle(fill_angle2),
        .sg_addr(sg_addr2), .busy(busy2), .done(done2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        start = 1'b0; req = 1'b0; s_val = 8'd0;
        start2 = 1'b0; req2 = 1'b0; s_val2 = 8'd0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0; req = 1'b0; s_val = 8'd0;
        start2 = 1'b0; req2 = 1'b0; s_val2 = 8'd0;
        repeat (3) tick();
        total++;
        if ({hs_angle, has_next, ack, fclr, fill_angle, sg_addr, busy, done} !== 40'd0)
            $display("FAIL reset_outputs: got angle=%0d has=%0b ack=%0b fclr=%0b fill=%0d addr=%0d busy=%0b done=%0b, want all 0",
                     hs_angle, has_next, ack, fclr, fill_angle, sg_addr, busy, done);
        else passed++;
        total++;
        if ({hs_angle2, has_next2, ack2, busy2, done2} !== 13'd0)
            $display("FAIL reset_outputs2: got angle=%0d has=%0b ack=%0b busy=%0b done=%0b, want all 0",
                     hs_angle2, has_next2, ack2, busy2, done2);
        else passed++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_request;
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({ack, fclr, busy, has_next} !== 4'b0000)
                $display("FAIL idle_req%0d: got ack=%0b fclr=%0b busy=%0b has=%0b, want 0000", i, ack, fclr, busy, has_next);
            else passed++;
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_single_scan;
        start = 1'b1; tick(); start = 1'b0;
        total++;
        if ({has_next, busy, hs_angle} !== {1'b1, 1'b1, 9'd0})
            $display("FAIL scan_start: got has=%0b busy=%0b angle=%0d, want 1 1 0", has_next, busy, hs_angle);
        else passed++;
        for (int k = 0; k < 9; k++) begin
            repeat (3) tick();
            if (k == 1) begin
                start = 1'b1; tick(); start = 1'b0;
                total++;
                if ({hs_angle, has_next, busy, ack} !== {9'd20, 1'b1, 1'b1, 1'b0})
                    $display("FAIL start_while_busy: got angle=%0d has=%0b busy=%0b ack=%0b, want 20 1 1 0", hs_angle, has_next, busy, ack);
                else passed++;
            end
            req = 1'b1; tick(); req = 1'b0;
            total++;
            if ({ack, fclr, fill_angle} !== {1'b1, 1'b1, 9'(20 * k)})
                $display("FAIL scan_ack%0d: got ack=%0b fclr=%0b fill=%0d, want 1 1 %0d", k, ack, fclr, fill_angle, 20 * k);
            else passed++;
            tick();
            total++;
            if (k < 8) begin
                if ({ack, fclr, has_next, hs_angle} !== {1'b0, 1'b0, 1'b1, 9'(20 * (k + 1))})
                    $display("FAIL scan_adv%0d: got ack=%0b fclr=%0b has=%0b angle=%0d, want 0 0 1 %0d", k, ack, fclr, has_next, hs_angle, 20 * (k + 1));
                else passed++;
            end else begin
                if ({ack, has_next, busy} !== 3'b001)
                    $display("FAIL scan_last: got ack=%0b has=%0b busy=%0b, want 0 0 1", ack, has_next, busy);
                else passed++;
            end
            if (k == 2) begin
                s_val = 8'd5; tick();
                total++;
                if (sg_addr !== 16'd517)
                    $display("FAIL addr_5: got %0d want 517", sg_addr);
                else passed++;
                s_val = 8'd255; tick();
                total++;
                if (sg_addr !== 16'd767)
                    $display("FAIL addr_255: got %0d want 767", sg_addr);
                else passed++;
                s_val = 8'd0;
            end
            repeat (4) tick();
        end
        req = 1'b1; tick(); req = 1'b0;
        total++;
`ifdef NABP_SEQ_REPEAT_EN
        if ({done, ack, fclr, busy} !== 4'b1001)
            $display("FAIL scan_done: got done=%0b ack=%0b fclr=%0b busy=%0b, want 1 0 0 1", done, ack, fclr, busy);
`else
        if ({done, ack, fclr, busy} !== 4'b1000)
            $display("FAIL scan_done: got done=%0b ack=%0b fclr=%0b busy=%0b, want 1 0 0 0", done, ack, fclr, busy);
`endif
        else passed++;
        tick();
        total++;
        if (done !== 1'b0)
            $display("FAIL done_width: got %0b want 0", done);
        else passed++;
    endtask

    task automatic test_held_request;
        int acks = 0;
        int fcls = 0;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        req = 1'b1;
        repeat (6) begin
            tick();
            acks += int'(ack);
            fcls += int'(fclr);
        end
        req = 1'b0;
        repeat (3) begin
            tick();
            acks += int'(ack);
            fcls += int'(fclr);
        end
        total++;
        if (acks != 1 || fcls != 1)
            $display("FAIL held_req_count: got acks=%0d clears=%0d, want 1 1", acks, fcls);
        else passed++;
        total++;
        if ({hs_angle, has_next} !== {9'd20, 1'b1})
            $display("FAIL held_req_angle: got angle=%0d has=%0b, want 20 1", hs_angle, has_next);
        else passed++;
        // After release the sequencer is back in OFFER: next ack is immediate.
        req = 1'b1; tick(); req = 1'b0;
        total++;
        if ({ack, fill_angle} !== {1'b1, 9'd20})
            $display("FAIL held_req_next: got ack=%0b fill=%0d, want 1 20", ack, fill_angle);
        else passed++;
    endtask

    task automatic test_reset_mid_scan;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req = 1'b1; tick(); req = 1'b0;
            repeat (3) tick();
        end
        total++;
        if ({fill_angle, hs_angle} !== {9'd60, 9'd80})
            $display("FAIL mid_scan_state: got fill=%0d angle=%0d, want 60 80", fill_angle, hs_angle);
        else passed++;
        reset_n = 1'b0;
        #2;
        total++;
        if ({hs_angle, has_next, ack, fclr, fill_angle, sg_addr, busy, done} !== 40'd0)
            $display("FAIL async_reset: got angle=%0d has=%0b fill=%0d addr=%0d busy=%0b, want all 0",
                     hs_angle, has_next, fill_angle, sg_addr, busy);
        else passed++;
        tick();
        reset_n = 1'b1;
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({ack, busy, has_next} !== 3'b000)
                $display("FAIL post_reset_req%0d: got ack=%0b busy=%0b has=%0b, want 000", i, ack, busy, has_next);
            else passed++;
        end
        req = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        total++;
        if ({hs_angle, has_next, busy} !== {9'd0, 1'b1, 1'b1})
            $display("FAIL restart: got angle=%0d has=%0b busy=%0b, want 0 1 1", hs_angle, has_next, busy);
        else passed++;
    endtask

    task automatic test_start_170;
        do_reset();
        start2 = 1'b1; tick(); start2 = 1'b0;
        total++;
        if ({hs_angle2, has_next2} !== {9'd170, 1'b1})
            $display("FAIL b170_start: got angle=%0d has=%0b, want 170 1", hs_angle2, has_next2);
        else passed++;
        repeat (2) tick();
        req2 = 1'b1; tick(); req2 = 1'b0;
        total++;
        if ({ack2, fclr2, fill_angle2} !== {1'b1, 1'b1, 9'd170})
            $display("FAIL b170_ack: got ack=%0b fclr=%0b fill=%0d, want 1 1 170", ack2, fclr2, fill_angle2);
        else passed++;
        tick();
        total++;
        if (has_next2 !== 1'b0)
            $display("FAIL b170_last: got has=%0b want 0", has_next2);
        else passed++;
        repeat (2) tick();
        req2 = 1'b1; tick(); req2 = 1'b0;
        total++;
        if ({done2, ack2} !== 2'b10)
            $display("FAIL b170_done: got done=%0b ack=%0b, want 1 0", done2, ack2);
        else passed++;
    endtask

`ifdef NABP_SEQ_REPEAT_EN
    task automatic test_repeat;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int r = 1; r <= 20; r++) begin
            repeat (3) tick();
            req = 1'b1; tick(); req = 1'b0;
            total++;
            if (r % 10 == 0) begin
                if ({done, ack, busy} !== 3'b101)
                    $display("FAIL repeat_drain%0d: got done=%0b ack=%0b busy=%0b, want 1 0 1", r, done, ack, busy);
                else passed++;
            end else begin
                if ({ack, done, busy, fill_angle} !== {1'b1, 1'b0, 1'b1, 9'(20 * ((r - 1) % 10))})
                    $display("FAIL repeat_ack%0d: got ack=%0b done=%0b busy=%0b fill=%0d, want 1 0 1 %0d",
                             r, ack, done, busy, fill_angle, 20 * ((r - 1) % 10));
                else passed++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_request();
        test_single_scan();
        test_held_request();
        test_reset_mid_scan();
        test_start_170();
`ifdef NABP_SEQ_REPEAT_EN
        test_repeat();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
